disp_scan_ctrl: RTL and testbench

// - Time-multiplexed scan scheduler for the multi-digit 7-segment display: shares one segment bus among NUM_DIGITS digits.
// - Rotates active-low digit enables at a fixed slot rate, with a dead-time blank between slots to suppress ghosting.
// - Decodes each digit's 4-bit value to segments. Sits between the BCD counters/timers and the board LED pins.

---
 rtl/disp_pkg.sv | 20 ++
 rtl/disp_seg7_decode.sv | 15 +
 rtl/disp_scan_ctrl.sv | 182 ++++++++++++++++++
 tb/tb_disp_scan_ctrl.sv | 177 +++++++++++++++++
 4 files changed

// File: rtl/disp_pkg.sv
// Shared definitions for the 7-segment display scan controller.
// Contents: FSM state constants, 16-entry glyph table ({g,f,e,d,c,b,a}), SEG_BLANK.
// Build option: LEADING_ZERO_BLANK_EN (consumed by disp_scan_ctrl).
package disp_pkg;

    typedef logic [1:0] state_t;

    localparam state_t ST_IDLE  = 2'd0;
    localparam state_t ST_SHOW  = 2'd1;
    localparam state_t ST_BLANK = 2'd2;

    localparam logic [7:0] SEG_BLANK = 8'h00;

    // Index 15 is leftmost: F,E,d,C,b,A,9..0
    localparam logic [15:0][6:0] GLYPH_TBL = {
        7'h71, 7'h79, 7'h5E, 7'h39, 7'h7C, 7'h77, 7'h6F, 7'h7F,
        7'h07, 7'h7D, 7'h6D, 7'h66, 7'h4F, 7'h5B, 7'h06, 7'h3F
    };

endpackage

// File: rtl/disp_seg7_decode.sv
// Combinational hex digit to 7-segment decoder with decimal point.
// Ports: i_val  - 4-bit digit value (0-F)
//        i_dp   - decimal point, active-high
//        o_seg_c- {dp,g,f,e,d,c,b,a}, active-high, combinational
module seg7_decode
    import disp_pkg::*;
(
    input  logic [3:0] i_val,
    input  logic       i_dp,
    output logic [7:0] o_seg_c
);

    assign o_seg_c = {i_dp, GLYPH_TBL[i_val]};

endmodule

// File: rtl/disp_scan_ctrl.sv
// Time-multiplexed scan scheduler for a multi-digit 7-segment display.
// Rotates one active-low digit enable per slot, with an optional all-dark
// dead time between slots, and drives the decoded glyph of a per-slot snapshot.
// Ports: clk, rst (sync, active-high), en (scan enable),
//        digits_in (4 bits per digit, digit 0 LSB), dp_in (per-digit dp),
//        led_en (active-low enables), led_seg ({dp,g..a}), digit_sel,
//        frame_tick (pulse on first SHOW cycle of digit 0 after a wrap).
// Build option: LEADING_ZERO_BLANK_EN blanks leading zero digits (digit 0 never).
module disp_scan_ctrl
    import disp_pkg::*;
#(
    parameter int unsigned NUM_DIGITS  = 8,
    parameter int unsigned SCAN_DIV    = 100000,
    parameter int unsigned DEAD_CYCLES = 1000
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          en,
    input  logic [4*NUM_DIGITS-1:0]       digits_in,
    input  logic [NUM_DIGITS-1:0]         dp_in,
    output logic [NUM_DIGITS-1:0]         led_en,
    output logic [7:0]                    led_seg,
    output logic [$clog2(NUM_DIGITS)-1:0] digit_sel,
    output logic                          frame_tick
);

    localparam int unsigned SEL_W     = $clog2(NUM_DIGITS);
    localparam int unsigned CNT_MAX   = (SCAN_DIV > DEAD_CYCLES) ? SCAN_DIV : DEAD_CYCLES;
    localparam int unsigned CNT_W     = $clog2(CNT_MAX + 1);
    localparam int unsigned SHOW_LAST = SCAN_DIV - 1;
    localparam int unsigned DEAD_LAST = (DEAD_CYCLES != 0) ? DEAD_CYCLES - 1 : 0;
    localparam bit          HAS_DEAD  = (DEAD_CYCLES != 0);

    state_t             r_state, w_state_nxt;
    logic [CNT_W-1:0]   r_cnt, w_cnt_nxt;
    logic [SEL_W-1:0]   r_sel, w_sel_nxt, w_sel_inc;
    logic               w_enter_show, w_wrap;

    logic [3:0]         r_snap_val, w_snap_val_nxt, w_live_val;
    logic               r_snap_dp, w_snap_dp_nxt, w_live_dp;
    logic               r_snap_blank, w_snap_blank_nxt, w_live_blank;

    logic [NUM_DIGITS-1:0] r_led_en, w_led_en_nxt;
    logic [7:0]            r_led_seg, w_led_seg_nxt, w_dec_seg;
    logic                  r_frame_tick;

    // Next digit index, wrapping at the last digit
    assign w_sel_inc = (r_sel == SEL_W'(NUM_DIGITS - 1)) ? '0 : r_sel + SEL_W'(1);

    // Next-state, slot counter and digit index
    always_comb begin
        w_state_nxt  = r_state;
        w_sel_nxt    = r_sel;
        w_cnt_nxt    = r_cnt + CNT_W'(1);
        w_enter_show = 1'b0;
        w_wrap       = 1'b0;
        case (r_state)
            ST_IDLE: begin
                w_cnt_nxt = '0;
                if (en) begin
                    w_state_nxt  = ST_SHOW;
                    w_sel_nxt    = '0;
                    w_enter_show = 1'b1;
                end
            end
            ST_SHOW: begin
                if (r_cnt == CNT_W'(SHOW_LAST)) begin
                    w_cnt_nxt = '0;
                    if (HAS_DEAD) begin
                        w_state_nxt = ST_BLANK;
                    end else begin
                        w_state_nxt  = ST_SHOW;
                        w_sel_nxt    = w_sel_inc;
                        w_enter_show = 1'b1;
                        w_wrap       = (r_sel == SEL_W'(NUM_DIGITS - 1));
                    end
                end
            end
            ST_BLANK: begin
                if (r_cnt == CNT_W'(DEAD_LAST)) begin
                    w_cnt_nxt    = '0;
                    w_state_nxt  = ST_SHOW;
                    w_sel_nxt    = w_sel_inc;
                    w_enter_show = 1'b1;
                    w_wrap       = (r_sel == SEL_W'(NUM_DIGITS - 1));
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
                w_cnt_nxt   = '0;
                w_sel_nxt   = '0;
            end
        endcase
        if (!en) begin
            w_state_nxt  = ST_IDLE;
            w_sel_nxt    = '0;
            w_cnt_nxt    = '0;
            w_enter_show = 1'b0;
            w_wrap       = 1'b0;
        end
    end

    // Live value/dp of the digit about to be shown, and its leading-zero status
    always_comb begin
        w_live_val   = 4'h0;
        w_live_dp    = 1'b0;
        w_live_blank = 1'b0;
        for (int i = 0; i < int'(NUM_DIGITS); i++) begin
            if (w_sel_nxt == SEL_W'(i)) begin
                w_live_val = digits_in[4*i +: 4];
                w_live_dp  = dp_in[i];
            end
        end
`ifdef LEADING_ZERO_BLANK_EN
        // Blank when this digit and every more-significant digit are zero
        w_live_blank = (w_sel_nxt != '0);
        for (int j = 0; j < int'(NUM_DIGITS); j++) begin
            if ((SEL_W'(j) >= w_sel_nxt) && (digits_in[4*j +: 4] != 4'h0)) begin
                w_live_blank = 1'b0;
            end
        end
`else
        w_live_blank = 1'b0;
`endif
    end

    // Snapshot is taken only on the edge entering SHOW
    assign w_snap_val_nxt   = w_enter_show ? w_live_val   : r_snap_val;
    assign w_snap_dp_nxt    = w_enter_show ? w_live_dp    : r_snap_dp;
    assign w_snap_blank_nxt = w_enter_show ? w_live_blank : r_snap_blank;

    seg7_decode u_dec (
        .i_val   (w_snap_val_nxt),
        .i_dp    (w_snap_dp_nxt),
        .o_seg_c (w_dec_seg)
    );

    // Output values for the coming cycle
    always_comb begin
        w_led_en_nxt  = '1;
        w_led_seg_nxt = SEG_BLANK;
        if (w_state_nxt == ST_SHOW) begin
            for (int i = 0; i < int'(NUM_DIGITS); i++) begin
                if (w_sel_nxt == SEL_W'(i)) begin
                    w_led_en_nxt[i] = 1'b0;
                end
            end
            w_led_seg_nxt = w_snap_blank_nxt ? {w_snap_dp_nxt, 7'h00} : w_dec_seg;
        end
    end

    // State, snapshot and output registers
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= ST_IDLE;
            r_cnt        <= '0;
            r_sel        <= '0;
            r_snap_val   <= 4'h0;
            r_snap_dp    <= 1'b0;
            r_snap_blank <= 1'b0;
            r_led_en     <= '1;
            r_led_seg    <= SEG_BLANK;
            r_frame_tick <= 1'b0;
        end else begin
            r_state      <= w_state_nxt;
            r_cnt        <= w_cnt_nxt;
            r_sel        <= w_sel_nxt;
            r_snap_val   <= w_snap_val_nxt;
            r_snap_dp    <= w_snap_dp_nxt;
            r_snap_blank <= w_snap_blank_nxt;
            r_led_en     <= w_led_en_nxt;
            r_led_seg    <= w_led_seg_nxt;
            r_frame_tick <= w_wrap;
        end
    end

    assign led_en     = r_led_en;
    assign led_seg    = r_led_seg;
    assign digit_sel  = r_sel;
    assign frame_tick = r_frame_tick;

endmodule

// File: tb/tb_disp_scan_ctrl.sv
// Bench for disp_scan_ctrl: two instances (dead time 2 and 0) driven by the same
// inputs and compared each cycle against a timeline model of the scan.
module tb_disp_scan_ctrl;

    localparam int N = 4;
    localparam int S = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic        en;
    logic [15:0] digits;
    logic [3:0]  dp;

    logic [3:0]  a_en,  b_en;
    logic [7:0]  a_seg, b_seg;
    logic [1:0]  a_sel, b_sel;
    logic        a_tick, b_tick;

    int checks = 0;
    int errors = 0;

    int          m_t   [2];
    bit          m_act [2];
    logic [3:0]  m_val [2];
    bit          m_dp  [2];
    bit          m_blk [2];

    always #5 clk = ~clk;

    disp_scan_ctrl #(.NUM_DIGITS(N), .SCAN_DIV(S), .DEAD_CYCLES(2)) u_dut_a (
        .clk(clk), .rst(rst), .en(en), .digits_in(digits), .dp_in(dp),
        .led_en(a_en), .led_seg(a_seg), .digit_sel(a_sel), .frame_tick(a_tick)
    );

    disp_scan_ctrl #(.NUM_DIGITS(N), .SCAN_DIV(S), .DEAD_CYCLES(0)) u_dut_b (
        .clk(clk), .rst(rst), .en(en), .digits_in(digits), .dp_in(dp),
        .led_en(b_en), .led_seg(b_seg), .digit_sel(b_sel), .frame_tick(b_tick)
    );

    function automatic logic [6:0] glyph(input logic [3:0] v);
        logic [6:0] tbl [16];
        tbl = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};
        return tbl[v];
    endfunction

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s t=%0t: got %h expected %h", tag, $time, obs, exp);
        end
    endtask

    // Advance the timeline of instance k across one clock edge
    task automatic model_edge(input int k, input int d);
        int per, p, slot;
        if (rst || !en) begin
            m_act[k] = 0;
        end else begin
            if (!m_act[k]) begin
                m_act[k] = 1;
                m_t[k]   = 0;
            end else begin
                m_t[k]++;
            end
            per  = S + d;
            p    = m_t[k] % (N * per);
            slot = p / per;
            if (p % per == 0) begin
                m_val[k] = 4'((digits >> (4 * slot)) & 16'h000F);
                m_dp[k]  = dp[slot];
`ifdef LEADING_ZERO_BLANK_EN
                m_blk[k] = (slot > 0) && ((digits >> (4 * slot)) == 16'h0);
`else
                m_blk[k] = 0;
`endif
            end
        end
    endtask

    task automatic check_inst(input int k, input int d, input logic [3:0] o_en,
                              input logic [7:0] o_seg, input logic [1:0] o_sel,
                              input logic o_tick);
        logic [3:0] e_en;
        logic [7:0] e_seg;
        logic [1:0] e_sel;
        logic       e_tick;
        int per, p, slot;
        e_en = 4'hF; e_seg = 8'h00; e_sel = 2'd0; e_tick = 1'b0;
        if (m_act[k]) begin
            per   = S + d;
            p     = m_t[k] % (N * per);
            slot  = p / per;
            e_sel = 2'(slot);
            e_tick = (p == 0) && (m_t[k] != 0);
            if (p % per < S) begin
                e_en  = ~(4'b0001 << slot);
                e_seg = m_blk[k] ? {m_dp[k], 7'h00} : {m_dp[k], glyph(m_val[k])};
            end
        end
        chk($sformatf("inst%0d led_en", k),     {4'h0, o_en},  {4'h0, e_en});
        chk($sformatf("inst%0d led_seg", k),    o_seg,         e_seg);
        chk($sformatf("inst%0d digit_sel", k),  {6'h0, o_sel}, {6'h0, e_sel});
        chk($sformatf("inst%0d frame_tick", k), {7'h0, o_tick}, {7'h0, e_tick});
    endtask

    int tick_cnt;

    task automatic step();
        @(posedge clk);
        model_edge(0, 2);
        model_edge(1, 0);
        #1;
        if (a_tick) tick_cnt++;
        check_inst(0, 2, a_en, a_seg, a_sel, a_tick);
        check_inst(1, 0, b_en, b_seg, b_sel, b_tick);
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    initial begin
        m_act = '{0, 0};
        m_t   = '{0, 0};
        m_val = '{4'h0, 4'h0};
        m_dp  = '{0, 0};
        m_blk = '{0, 0};
        tick_cnt = 0;

        // Reset held with en high: outputs stay dark
        rst = 1'b1; en = 1'b1; digits = 16'h3210; dp = 4'b0000;
        run(4);

        // Steady scan of 3210; dead-time instance should tick twice in 48 cycles
        rst = 1'b0;
        run(1);
        tick_cnt = 0;
        run(48);
        chk("frame_tick count", 8'(tick_cnt), 8'd2);

        // Change value while digit 1 is lit (t=6..9 in the dead-time timeline)
        for (int g = 0; g < 100 && (m_t[0] % 24) != 7; g++) step();
        chk("reached digit1 slot", 8'(m_t[0] % 24), 8'd7);
        digits = 16'h3250;
        run(30);

        // Drop enable during digit 2, then resume from digit 0
        for (int g = 0; g < 100 && (m_t[0] % 24) != 13; g++) step();
        chk("reached digit2 slot", 8'(m_t[0] % 24), 8'd13);
        en = 1'b0;
        run(2);
        en = 1'b1;
        run(10);

        // Leading-zero pattern with a decimal point on digit 1
        digits = 16'h00A7; dp = 4'b0010;
        run(30);

        // Randomized traffic including mid-slot resets and enable drops
        for (int i = 0; i < 800; i++) begin
            if ($urandom_range(0, 9) == 0) digits = 16'($urandom);
            if ($urandom_range(0, 19) == 0) dp = 4'($urandom);
            if ($urandom_range(0, 3) == 0) digits = digits & 16'h00FF;
            en  = ($urandom_range(0, 49) != 0);
            rst = ($urandom_range(0, 99) == 0);
            step();
        end
        rst = 1'b0; en = 1'b1;
        run(30);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
